// File: rtl/map_region_redraw.sv
// rtl/map_region_redraw.sv - windowed background redraw engine with optional sprite overlay hand-off
// Streams one ROM address per clock over a clamped window and replays it to the VGA port.
module map_region_redraw #(
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240,
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int COLOR_W     = 3,
  parameter int ROM_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [X_W-1:0]     x1,
  input  logic [Y_W-1:0]     y0,
  input  logic [Y_W-1:0]     y1,
  input  logic               char_en,
  input  logic               abort,
  output logic [X_W-1:0]     bg_x,
  output logic [Y_W-1:0]     bg_y,
  input  logic [COLOR_W-1:0] bg_color,
  output logic               char_draw,
  input  logic               char_done,
  input  logic               char_plot,
  input  logic [X_W-1:0]     char_x,
  input  logic [Y_W-1:0]     char_y,
  input  logic [COLOR_W-1:0] char_color,
  output logic               plot,
  output logic [X_W-1:0]     X,
  output logic [Y_W-1:0]     Y,
  output logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done
);

  localparam logic [X_W-1:0] X_MAX      = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX      = Y_W'(SCREEN_H - 1);
  localparam logic [1:0]     DRAIN_LAST = 2'(ROM_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, CHAR, DONE} state_t;

  state_t                   state_q, state_d;
  logic [X_W-1:0]           cx0_q, cx0_d, cx1_q, cx1_d;
  logic [Y_W-1:0]           cy0_q, cy0_d, cy1_q, cy1_d;
  logic                     char_en_q, char_en_d;
  logic [X_W-1:0]           ax_q, ax_d;
  logic [Y_W-1:0]           ay_q, ay_d;
  logic [1:0]               drain_q, drain_d;
  logic [ROM_LATENCY-1:0]   pv_q, pv_d;
  logic [X_W-1:0]           px_q [ROM_LATENCY];
  logic [X_W-1:0]           px_d [ROM_LATENCY];
  logic [Y_W-1:0]           py_q [ROM_LATENCY];
  logic [Y_W-1:0]           py_d [ROM_LATENCY];

  logic [X_W-1:0] cx0_c, cx1_c;
  logic [Y_W-1:0] cy0_c, cy1_c;
  logic           win_empty;

  assign cx0_c     = (x0 > X_MAX) ? X_MAX : x0;
  assign cx1_c     = (x1 > X_MAX) ? X_MAX : x1;
  assign cy0_c     = (y0 > Y_MAX) ? Y_MAX : y0;
  assign cy1_c     = (y1 > Y_MAX) ? Y_MAX : y1;
  assign win_empty = (cx0_c > cx1_c) || (cy0_c > cy1_c);

  always_comb begin
    state_d   = state_q;
    cx0_d     = cx0_q;
    cx1_d     = cx1_q;
    cy0_d     = cy0_q;
    cy1_d     = cy1_q;
    char_en_d = char_en_q;
    ax_d      = ax_q;
    ay_d      = ay_q;
    drain_d   = drain_q;

    // Delay line entry 0 takes the address presented this cycle; SCAN marks it valid.
    pv_d[0] = 1'b0;
    px_d[0] = ax_q;
    py_d[0] = ay_q;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      px_d[i] = px_q[i-1];
      py_d[i] = py_q[i-1];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          cx0_d     = cx0_c;
          cx1_d     = cx1_c;
          cy0_d     = cy0_c;
          cy1_d     = cy1_c;
          char_en_d = char_en;
          if (win_empty) begin
            state_d = char_en ? CHAR : DONE;
          end else begin
            state_d = SCAN;
            ax_d    = cx0_c;
            ay_d    = cy0_c;
          end
        end
      end
      SCAN: begin
        pv_d[0] = 1'b1;
        if (ax_q == cx1_q) begin
          if (ay_q == cy1_q) begin
            // Counter parks on the last address so it never runs past the window.
            state_d = DRAIN;
            drain_d = 2'd0;
          end else begin
            ax_d = cx0_q;
            ay_d = ay_q + 1'b1;
          end
        end else begin
          ax_d = ax_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = char_en_q ? CHAR : DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      CHAR: begin
        if (char_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
      ax_d    = '0;
      ay_d    = '0;
      pv_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cx0_q     <= '0;
      cx1_q     <= '0;
      cy0_q     <= '0;
      cy1_q     <= '0;
      char_en_q <= 1'b0;
      ax_q      <= '0;
      ay_q      <= '0;
      drain_q   <= '0;
      pv_q      <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cx0_q     <= cx0_d;
      cx1_q     <= cx1_d;
      cy0_q     <= cy0_d;
      cy1_q     <= cy1_d;
      char_en_q <= char_en_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      drain_q   <= drain_d;
      pv_q      <= pv_d;
      px_q      <= px_d;
      py_q      <= py_d;
    end
  end

  logic in_char;
  assign in_char = (state_q == CHAR);

  always_comb begin
    bg_x      = ax_q;
    bg_y      = ay_q;
    char_draw = in_char;
    busy      = (state_q == SCAN) || (state_q == DRAIN) || in_char;
    done      = (state_q == DONE);
    if (in_char) begin
      plot  = char_plot;
      X     = char_x;
      Y     = char_y;
      color = char_color;
    end else begin
      plot  = pv_q[ROM_LATENCY-1];
      X     = px_q[ROM_LATENCY-1];
      Y     = py_q[ROM_LATENCY-1];
      color = bg_color;
    end
  end

endmodule

// File: tb/tb_map_region_redraw.sv
// tb/tb_map_region_redraw.sv - randomized self-checking bench for map_region_redraw
// Expected plot streams are derived from window rules and a behavioural ROM/sprite model.
module tb_map_region_redraw;

  localparam int L = 3;

  logic       clock;
  logic       reset;
  logic       start;
  logic [8:0] x0, x1;
  logic [7:0] y0, y1;
  logic       char_en;
  logic       abort;
  logic [8:0] bg_x;
  logic [7:0] bg_y;
  logic [2:0] bg_color;
  logic       char_draw;
  logic       char_done;
  logic       char_plot;
  logic [8:0] char_x;
  logic [7:0] char_y;
  logic [2:0] char_color;
  logic       plot;
  logic [8:0] X;
  logic [7:0] Y;
  logic [2:0] color;
  logic       busy;
  logic       done;

  map_region_redraw #(.ROM_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .char_en(char_en), .abort(abort),
    .bg_x(bg_x), .bg_y(bg_y), .bg_color(bg_color),
    .char_draw(char_draw), .char_done(char_done), .char_plot(char_plot),
    .char_x(char_x), .char_y(char_y), .char_color(char_color),
    .plot(plot), .X(X), .Y(Y), .color(color),
    .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int rom(input int x, input int y);
    return (x * 5 + y * 3 + (x >> 4)) & 7;
  endfunction

  // Background ROM: data answers the address seen L clocks earlier.
  int hx [L];
  int hy [L];
  always @(posedge clock) begin
    hx[0] <= int'(bg_x);
    hy[0] <= int'(bg_y);
    for (int i = 1; i < L; i++) begin
      hx[i] <= hx[i-1];
      hy[i] <= hy[i-1];
    end
  end
  assign bg_color = 3'(rom(hx[L-1], hy[L-1]));

  typedef struct {
    int cyc;
    int x;
    int y;
    int c;
  } pix_t;

  int n_checks = 0;
  int n_pass   = 0;
  int spr_k    = 0;
  bit bg_zero  = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // stop_kind: 0 run to done, 1 abort at stop_at, 2 reset at stop_at
  task automatic do_op(input string name, input int ix0, input int ix1, input int iy0, input int iy1,
                       input bit cen, input int n_spr, input int dly,
                       input int stop_kind, input int stop_at, input bit stray);
    pix_t exp_q[$];
    pix_t obs_q[$];
    pix_t p;
    int cx0, cx1, cy0, cy1, n, c0, exp_done, end_busy, limit, done_cyc, busy_bad, mism, i;
    bit exp_busy;

    cx0 = imin(ix0, 319);
    cx1 = imin(ix1, 319);
    cy0 = imin(iy0, 239);
    cy1 = imin(iy1, 239);
    n = (cx0 <= cx1 && cy0 <= cy1) ? (cx1 - cx0 + 1) * (cy1 - cy0 + 1) : 0;
    i = 0;
    if (n > 0) begin
      for (int y = cy0; y <= cy1; y++) begin
        for (int x = cx0; x <= cx1; x++) begin
          p.cyc = 1 + L + i; p.x = x; p.y = y; p.c = rom(x, y);
          exp_q.push_back(p);
          i++;
        end
      end
    end
    c0 = (n > 0) ? n + L + 1 : 1;
    if (cen) begin
      for (int k = 1; k <= imin(n_spr, dly); k++) begin
        p.cyc = c0 + k; p.x = 200 + k; p.y = 100 + k; p.c = k & 7;
        exp_q.push_back(p);
      end
      exp_done = c0 + dly + 1;
    end else begin
      exp_done = c0;
    end
    if (stop_kind != 0) begin
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > stop_at) void'(exp_q.pop_back());
      end_busy = stop_at + 1;
      limit    = stop_at;
    end else begin
      end_busy = exp_done;
      limit    = exp_done + 40;
    end

    done_cyc = -1;
    busy_bad = 0;
    for (int cyc = 0; cyc <= limit; cyc++) begin
      @(posedge clock);
      #1;
      abort = 1'b0;
      reset = 1'b0;
      if (cyc == 0) begin
        start = 1'b1;
        x0 = 9'(ix0); x1 = 9'(ix1); y0 = 8'(iy0); y1 = 8'(iy1);
        char_en = cen;
      end else begin
        start = stray && (cyc <= end_busy) ? 1'($urandom) : 1'b0;
        x0 = 9'($urandom); x1 = 9'($urandom); y0 = 8'($urandom); y1 = 8'($urandom);
        char_en = 1'($urandom);
      end
      if (stop_kind == 1 && cyc == stop_at) abort = 1'b1;
      if (stop_kind == 2 && cyc == stop_at) reset = 1'b1;
      if (char_draw) begin
        char_plot  = (spr_k >= 1 && spr_k <= n_spr);
        char_x     = 9'(200 + spr_k);
        char_y     = 8'(100 + spr_k);
        char_color = 3'(spr_k & 7);
        char_done  = (spr_k == dly);
        spr_k++;
      end else begin
        spr_k      = 0;
        char_plot  = 1'($urandom);
        char_x     = 9'($urandom);
        char_y     = 8'($urandom);
        char_color = 3'($urandom);
        char_done  = 1'($urandom);
      end

      @(negedge clock);
      if (cyc == 0) begin
        check_eq({name, " idle_plot"}, 32'(plot), 0);
        check_eq({name, " idle_busy"}, 32'(busy), 0);
        check_eq({name, " idle_done"}, 32'(done), 0);
        check_eq({name, " idle_char_draw"}, 32'(char_draw), 0);
        if (bg_zero) begin
          check_eq({name, " idle_bg_x"}, 32'(bg_x), 0);
          check_eq({name, " idle_bg_y"}, 32'(bg_y), 0);
          bg_zero = 1'b0;
        end
      end
      if (plot) begin
        p.cyc = cyc; p.x = int'(X); p.y = int'(Y); p.c = int'(color);
        obs_q.push_back(p);
      end
      exp_busy = (cyc >= 1) && (cyc < end_busy);
      if (busy !== exp_busy) busy_bad++;
      if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      if (stop_kind == 0 && done === 1'b1) break;
    end

    mism = 0;
    for (int j = 0; j < imin(exp_q.size(), obs_q.size()); j++) begin
      if (obs_q[j] != exp_q[j]) begin
        if (mism == 0)
          $display("%s plot %0d: got cyc %0d (%0d,%0d) c%0d want cyc %0d (%0d,%0d) c%0d", name, j,
                   obs_q[j].cyc, obs_q[j].x, obs_q[j].y, obs_q[j].c,
                   exp_q[j].cyc, exp_q[j].x, exp_q[j].y, exp_q[j].c);
        mism++;
      end
    end
    check_eq({name, " plot_count"}, obs_q.size(), exp_q.size());
    check_eq({name, " plot_mismatches"}, mism, 0);
    check_eq({name, " done_cycle"}, done_cyc, (stop_kind != 0) ? -1 : exp_done);
    check_eq({name, " busy_mismatches"}, busy_bad, 0);
    if (stop_kind != 0) bg_zero = 1'b1;
  endtask

  initial begin
    int rx0, rx1, ry0, ry1, rn;
    reset = 1'b1; start = 1'b0; abort = 1'b0; char_en = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    char_done = 1'b0; char_plot = 1'b0; char_x = '0; char_y = '0; char_color = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    do_op("full", 0, 319, 0, 239, 1'b0, 0, 0, 0, 0, 1'b0);
    do_op("small", 10, 12, 20, 21, 1'b0, 0, 0, 0, 0, 1'b1);
    do_op("clamp", 315, 400, 238, 250, 1'b0, 0, 0, 0, 0, 1'b0);
    do_op("empty_char", 50, 40, 5, 6, 1'b1, 4, 7, 0, 0, 1'b1);
    do_op("abort", 5, 30, 5, 8, 1'b0, 0, 0, 1, 6, 1'b0);
    do_op("after_abort", 7, 9, 9, 10, 1'b0, 0, 0, 0, 0, 1'b0);
    do_op("reset_char", 100, 103, 50, 51, 1'b1, 3, 6, 2, 15, 1'b1);
    do_op("after_reset", 0, 1, 0, 0, 1'b1, 2, 3, 0, 0, 1'b1);

    for (int t = 0; t < 20; t++) begin
      rx0 = $urandom_range(0, 330);
      rx1 = rx0 + $urandom_range(0, 10) - 3;
      if (rx1 < 0) rx1 = 0;
      ry0 = $urandom_range(0, 245);
      ry1 = ry0 + $urandom_range(0, 3) - 1;
      if (ry1 < 0) ry1 = 0;
      if (ry1 > 255) ry1 = 255;
      rn = $urandom_range(0, 4);
      do_op($sformatf("rand%0d", t), rx0, rx1, ry0, ry1, 1'($urandom), rn,
            rn + $urandom_range(1, 4), 0, 0, 1'($urandom));
    end

    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/map_region_redraw.md
Name: map_region_redraw

Overview:
- Parametrised background-redraw engine that repaints an arbitrary rectangular window of the map from the background ROM, then optionally hands the VGA port to the sprite drawer for a character overlay.
- Replaces the full-screen, three-cycles-per-pixel map redraw. Streams one pixel per clock through a ROM of configurable latency.
- Supports clipping, abort and a start/done pulse handshake.
- Sits between the game-state controller (start/done), the background ROM (address/color) and the VGA adapter (plot/X/Y/color).

Parameters:
- SCREEN_W, 320, screen width in pixels.
- SCREEN_H, 240, screen height in pixels.
- X_W, 9, X coordinate width; must satisfy 2^X_W >= SCREEN_W.
- Y_W, 8, Y coordinate width; must satisfy 2^Y_W >= SCREEN_H.
- COLOR_W, 3, pixel color width.
- ROM_LATENCY, 1, clocks from bg_x/bg_y to a valid bg_color; range 1..4.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- x0, x1  in  X_W  inclusive window column bounds; sampled at start.
- y0, y1  in  Y_W  inclusive window row bounds; sampled at start.
- char_en  in  1  run the character overlay phase after the scan; sampled at start.
- abort  in  1  cancel the operation.
- bg_x  out  X_W  background ROM column address.
- bg_y  out  Y_W  background ROM row address.
- bg_color  in  COLOR_W  ROM data, valid ROM_LATENCY cycles after the address.
- char_draw  out  1  level; sprite drawer runs while high.
- char_done  in  1  sprite drawer finished.
- char_plot  in  1  sprite drawer pixel strobe, forwarded during the overlay phase.
- char_x  in  X_W  sprite drawer column, forwarded during the overlay phase.
- char_y  in  Y_W  sprite drawer row, forwarded during the overlay phase.
- char_color  in  COLOR_W  sprite drawer color, forwarded during the overlay phase.
- plot  out  1  VGA write strobe.
- X  out  X_W  VGA column.
- Y  out  Y_W  VGA row.
- color  out  COLOR_W  VGA color.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset, and abort asserted in any state, force the following on the next edge:
  - state IDLE;
  - plot, busy, done, char_draw = 0;
  - bg_x/bg_y = 0;
  - the delay pipeline is flushed (all valid bits cleared).
- No done pulse is issued for an aborted operation. Abort has priority over start in the same cycle.
- States: IDLE, SCAN, DRAIN, CHAR, DONE.
- IDLE:
  - When start=1, latch the window, clamped to the screen:
    - cx0 = min(x0, SCREEN_W-1), cx1 = min(x1, SCREEN_W-1);
    - cy0 = min(y0, SCREEN_H-1), cy1 = min(y1, SCREEN_H-1).
  - If cx0>cx1 or cy0>cy1, the window is empty: go to CHAR if char_en=1, else DONE.
  - Otherwise go to SCAN with the address counter at (cx0, cy0).
- SCAN:
  - Each cycle, present the counter on bg_x/bg_y and push {valid=1, x, y} into a ROM_LATENCY-deep delay line.
  - Raster order: x increments; at cx1, x wraps to cx0 and y increments.
  - The cycle that presents (cx1, cy1) transitions to DRAIN.
  - Exactly (cx1-cx0+1)*(cy1-cy0+1) addresses are issued, with no gaps.
- DRAIN: push valid=0 for ROM_LATENCY cycles, then go to CHAR if char_en, else DONE.
- Pixel output, outside CHAR:
  - plot = head-of-line valid;
  - X/Y = head-of-line coordinates;
  - color = bg_color.
  - The first plot occurs ROM_LATENCY cycles after the first SCAN cycle.
  - The last plot occurs in the final DRAIN cycle.
- CHAR:
  - char_draw = 1.
  - plot/X/Y/color are driven combinationally from char_plot/char_x/char_y/char_color.
  - On a cycle with char_done=1, go to DONE.
  - No timeout.
- DONE: done = 1 for one cycle, busy = 0, return to IDLE.
- A start asserted while busy=1 is ignored and not queued.
- A start in the same cycle as done is not accepted. It is accepted the following cycle if still asserted.
- Outside CHAR, all char_* inputs are ignored.
- Counters never exceed cx1/cy1, so no wrap past screen edges.

Test Plan:
- Defaults, ROM_LATENCY=1, start with (0,0)-(319,239), char_en=0 → 76800 plots, first (0,0), last (319,239), consecutive-cycle plots, done pulse one cycle after the last plot.
- ROM_LATENCY=3, window (10,20)-(12,21) → 6 plots in the order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), first plot 3 cycles after the first SCAN cycle, each color equal to the ROM model's value for that coordinate.
- Window (315,238)-(400,250) → clamped to (315,238)-(319,239): 10 plots, no X>319 or Y>239.
- Window x0=50, x1=40, char_en=1, sprite model raises char_done 7 cycles after char_draw, emitting 4 char_plot pixels → 0 background plots, 4 forwarded plots, done one cycle after char_done.
- Abort during SCAN after the 5th address → no further plots (pipeline flushed), busy=0, no done. A new start the next cycle begins cleanly at its own (cx0, cy0).
- Start pulse while busy, and reset asserted mid-CHAR → second start ignored (single done). On reset, all outputs are 0 on the next edge and char_draw drops.
